id_ex_stage: RTL and testbench

- ID/EX pipeline register plus execute-stage operand forwarding for the 5-stage MIPS pipeline.
- Sits directly upstream of the ALU:
  - captures decoded operands and control each cycle;
  - resolves RAW hazards from the MEM and WB stages;
  - drives the ALU `a`, `b` and 3-bit `alucont` inputs;
  - reports load-use stalls back to the hazard unit.

---
 rtl/id_ex_stage.sv | 169 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Brief    : ID/EX pipeline register with MEM/WB operand forwarding and
//             load-use detection, feeding the execute-stage ALU.
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
   parameter int WIDTH = 32,
   parameter int RADDR = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_e,
   input  logic             flush_e,
   input  logic             valid_d,
   input  logic [WIDTH-1:0] rd1_d,
   input  logic [WIDTH-1:0] rd2_d,
   input  logic [WIDTH-1:0] signimm_d,
   input  logic [RADDR-1:0] rs_d,
   input  logic [RADDR-1:0] rt_d,
   input  logic [RADDR-1:0] rd_d,
   input  logic [2:0]       alucontrol_d,
   input  logic             alusrc_d,
   input  logic             regdst_d,
   input  logic             regwrite_d,
   input  logic             memtoreg_d,
   input  logic             memwrite_d,
   input  logic [WIDTH-1:0] aluout_m,
   input  logic             regwrite_m,
   input  logic [RADDR-1:0] writereg_m,
   input  logic [WIDTH-1:0] result_w,
   input  logic             regwrite_w,
   input  logic [RADDR-1:0] writereg_w,
   output logic [WIDTH-1:0] srca_e,
   output logic [WIDTH-1:0] srcb_e,
   output logic [2:0]       alucont_e,
   output logic [WIDTH-1:0] writedata_e,
   output logic [RADDR-1:0] writereg_e,
   output logic             regwrite_e,
   output logic             memtoreg_e,
   output logic             memwrite_e,
   output logic             valid_e,
   output logic [1:0]       forward_a_e,
   output logic [1:0]       forward_b_e,
   output logic             lwstall_d
);

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] rd1;
      logic [WIDTH-1:0] rd2;
      logic [WIDTH-1:0] signimm;
      logic [RADDR-1:0] rs;
      logic [RADDR-1:0] rt;
      logic [RADDR-1:0] rd;
      logic [2:0]       alucontrol;
      logic             alusrc;
      logic             regdst;
      logic             regwrite;
      logic             memtoreg;
      logic             memwrite;
   } idex_t;

   localparam logic [1:0] c_fwd_rf  = 2'b00;
   localparam logic [1:0] c_fwd_mem = 2'b10;
   localparam logic [1:0] c_fwd_wb  = 2'b01;

   // A bubble is an all-zero instruction whose ALU op is add.
   localparam idex_t c_bubble = '{
      valid:      1'b0,
      rd1:        '0,
      rd2:        '0,
      signimm:    '0,
      rs:         '0,
      rt:         '0,
      rd:         '0,
      alucontrol: 3'b010,
      alusrc:     1'b0,
      regdst:     1'b0,
      regwrite:   1'b0,
      memtoreg:   1'b0,
      memwrite:   1'b0
   };

   idex_t idex_d;
   idex_t idex_q;

   always_comb begin
      idex_d = idex_q;
      if (flush_e) begin
         idex_d = c_bubble;
      end else if (!stall_e) begin
         idex_d.valid      = valid_d;
         idex_d.rd1        = rd1_d;
         idex_d.rd2        = rd2_d;
         idex_d.signimm    = signimm_d;
         idex_d.rs         = rs_d;
         idex_d.rt         = rt_d;
         idex_d.rd         = rd_d;
         idex_d.alucontrol = alucontrol_d;
         idex_d.alusrc     = alusrc_d;
         idex_d.regdst     = regdst_d;
         idex_d.regwrite   = regwrite_d;
         idex_d.memtoreg   = memtoreg_d;
         idex_d.memwrite   = memwrite_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idex_q <= c_bubble;
      end else begin
         idex_q <= idex_d;
      end
   end

   logic             hit_m_a;
   logic             hit_w_a;
   logic             hit_m_b;
   logic             hit_w_b;
   logic [WIDTH-1:0] fwd_a;
   logic [WIDTH-1:0] fwd_b;

   // $0 is never a forwarding target, so its register-file zero passes through.
   assign hit_m_a = regwrite_m && (writereg_m != '0) && (writereg_m == idex_q.rs);
   assign hit_w_a = regwrite_w && (writereg_w != '0) && (writereg_w == idex_q.rs);
   assign hit_m_b = regwrite_m && (writereg_m != '0) && (writereg_m == idex_q.rt);
   assign hit_w_b = regwrite_w && (writereg_w != '0) && (writereg_w == idex_q.rt);

   always_comb begin
      fwd_a       = idex_q.rd1;
      forward_a_e = c_fwd_rf;
      if (hit_m_a) begin
         fwd_a       = aluout_m;
         forward_a_e = c_fwd_mem;
      end else if (hit_w_a) begin
         fwd_a       = result_w;
         forward_a_e = c_fwd_wb;
      end
   end

   always_comb begin
      fwd_b       = idex_q.rd2;
      forward_b_e = c_fwd_rf;
      if (hit_m_b) begin
         fwd_b       = aluout_m;
         forward_b_e = c_fwd_mem;
      end else if (hit_w_b) begin
         fwd_b       = result_w;
         forward_b_e = c_fwd_wb;
      end
   end

   assign srca_e      = fwd_a;
   assign writedata_e = fwd_b;
   assign srcb_e      = idex_q.alusrc ? idex_q.signimm : fwd_b;
   assign writereg_e  = idex_q.regdst ? idex_q.rd : idex_q.rt;
   assign alucont_e   = idex_q.alucontrol;
   assign regwrite_e  = idex_q.regwrite;
   assign memtoreg_e  = idex_q.memtoreg;
   assign memwrite_e  = idex_q.memwrite;
   assign valid_e     = idex_q.valid;

   assign lwstall_d = idex_q.valid && idex_q.memtoreg && (idex_q.rt != '0) &&
                      ((idex_q.rt == rs_d) || (idex_q.rt == rt_d));

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Brief    : Self-checking scoreboard bench for id_ex_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall_e, flush_e, valid_d;
   logic [31:0] rd1_d, rd2_d, signimm_d;
   logic [4:0]  rs_d, rt_d, rd_d;
   logic [2:0]  alucontrol_d;
   logic        alusrc_d, regdst_d, regwrite_d, memtoreg_d, memwrite_d;
   logic [31:0] aluout_m, result_w;
   logic        regwrite_m, regwrite_w;
   logic [4:0]  writereg_m, writereg_w;
   logic [31:0] srca_e, srcb_e, writedata_e;
   logic [2:0]  alucont_e;
   logic [4:0]  writereg_e;
   logic        regwrite_e, memtoreg_e, memwrite_e, valid_e;
   logic [1:0]  forward_a_e, forward_b_e;
   logic        lwstall_d;

   id_ex_stage #(.WIDTH(32), .RADDR(5)) dut (
      .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
      .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d),
      .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .alucontrol_d(alucontrol_d),
      .alusrc_d(alusrc_d), .regdst_d(regdst_d), .regwrite_d(regwrite_d),
      .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
      .aluout_m(aluout_m), .regwrite_m(regwrite_m), .writereg_m(writereg_m),
      .result_w(result_w), .regwrite_w(regwrite_w), .writereg_w(writereg_w),
      .srca_e(srca_e), .srcb_e(srcb_e), .alucont_e(alucont_e),
      .writedata_e(writedata_e), .writereg_e(writereg_e),
      .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
      .valid_e(valid_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .lwstall_d(lwstall_d)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] srca, srcb, wd;
      logic [2:0]  alucont;
      logic [1:0]  fa, fb;
      logic [4:0]  wr;
      logic        valid, regwrite, memtoreg, memwrite, lwstall;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   function automatic exp_t bubble();
      exp_t e;
      e.srca = '0; e.srcb = '0; e.wd = '0; e.alucont = 3'b010;
      e.fa = 2'b00; e.fb = 2'b00; e.wr = '0;
      e.valid = 1'b0; e.regwrite = 1'b0; e.memtoreg = 1'b0;
      e.memwrite = 1'b0; e.lwstall = 1'b0;
      return e;
   endfunction

   task automatic compare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
      end else begin
         e = sb.pop_front();
         check({tag, ".srca"},     srca_e,      e.srca);
         check({tag, ".srcb"},     srcb_e,      e.srcb);
         check({tag, ".wdata"},    writedata_e, e.wd);
         check({tag, ".alucont"},  {29'd0, alucont_e},   {29'd0, e.alucont});
         check({tag, ".fwd_a"},    {30'd0, forward_a_e}, {30'd0, e.fa});
         check({tag, ".fwd_b"},    {30'd0, forward_b_e}, {30'd0, e.fb});
         check({tag, ".wreg"},     {27'd0, writereg_e},  {27'd0, e.wr});
         check({tag, ".valid"},    {31'd0, valid_e},     {31'd0, e.valid});
         check({tag, ".regwrite"}, {31'd0, regwrite_e},  {31'd0, e.regwrite});
         check({tag, ".memtoreg"}, {31'd0, memtoreg_e},  {31'd0, e.memtoreg});
         check({tag, ".memwrite"}, {31'd0, memwrite_e},  {31'd0, e.memwrite});
         check({tag, ".lwstall"},  {31'd0, lwstall_d},   {31'd0, e.lwstall});
      end
   endtask

   task automatic clear_inputs();
      stall_e = 0; flush_e = 0; valid_d = 0;
      rd1_d = 0; rd2_d = 0; signimm_d = 0; rs_d = 0; rt_d = 0; rd_d = 0;
      alucontrol_d = 3'b000; alusrc_d = 0; regdst_d = 0; regwrite_d = 0;
      memtoreg_d = 0; memwrite_d = 0;
      aluout_m = 0; regwrite_m = 0; writereg_m = 0;
      result_w = 0; regwrite_w = 0; writereg_w = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      clear_inputs();
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      sb.push_back(bubble());
      compare("reset_init");
      @(negedge clk);
      reset = 0;

      // Capture then asynchronous reset mid-cycle
      valid_d = 1; rd1_d = 32'hAB; rs_d = 3; rt_d = 4; rd_d = 6; regdst_d = 1;
      alucontrol_d = 3'b111; regwrite_d = 1;
      e = bubble(); e.srca = 32'hAB; e.alucont = 3'b111; e.wr = 6;
      e.valid = 1; e.regwrite = 1;
      sb.push_back(e);
      tick();
      compare("pre_reset_capture");
      #2 reset = 1;
      #1;
      sb.push_back(bubble());
      compare("async_reset");
      @(negedge clk);
      reset = 0;

      // Plain capture
      clear_inputs();
      valid_d = 1; rd1_d = 5; rd2_d = 3; rs_d = 1; rt_d = 2; rd_d = 3;
      regdst_d = 1; regwrite_d = 1; alucontrol_d = 3'b110;
      e = bubble(); e.srca = 5; e.srcb = 3; e.wd = 3; e.alucont = 3'b110;
      e.wr = 3; e.valid = 1; e.regwrite = 1;
      sb.push_back(e);
      tick();
      compare("plain");

      // Double hazard: MEM beats WB, then WB, then register file
      @(negedge clk);
      clear_inputs();
      valid_d = 1; rs_d = 8; rt_d = 8; rd1_d = 32'hAAAA; rd2_d = 32'hBBBB;
      alucontrol_d = 3'b010; regwrite_d = 1;
      regwrite_m = 1; writereg_m = 8; aluout_m = 32'h1111_1111;
      regwrite_w = 1; writereg_w = 8; result_w = 32'h2222_2222;
      e = bubble(); e.srca = 32'h1111_1111; e.srcb = 32'h1111_1111;
      e.wd = 32'h1111_1111; e.fa = 2'b10; e.fb = 2'b10; e.wr = 8;
      e.valid = 1; e.regwrite = 1;
      sb.push_back(e);
      tick();
      compare("dbl_mem");
      @(negedge clk);
      stall_e = 1; regwrite_m = 0;
      e.srca = 32'h2222_2222; e.srcb = 32'h2222_2222; e.wd = 32'h2222_2222;
      e.fa = 2'b01; e.fb = 2'b01;
      sb.push_back(e);
      tick();
      compare("dbl_wb");
      @(negedge clk);
      regwrite_w = 0;
      e.srca = 32'hAAAA; e.srcb = 32'hBBBB; e.wd = 32'hBBBB;
      e.fa = 2'b00; e.fb = 2'b00;
      sb.push_back(e);
      tick();
      compare("dbl_rf");

      // $0 never forwarded; immediate selects signimm
      @(negedge clk);
      clear_inputs();
      valid_d = 1; rs_d = 0; rt_d = 5; rd1_d = 0; rd2_d = 32'h55;
      alusrc_d = 1; signimm_d = 32'hFFFF_FFF0; alucontrol_d = 3'b010; regwrite_d = 1;
      regwrite_m = 1; writereg_m = 0; aluout_m = 32'hFFFF_FFFF;
      regwrite_w = 1; writereg_w = 0; result_w = 32'h1234;
      e = bubble(); e.srca = 0; e.srcb = 32'hFFFF_FFF0; e.wd = 32'h55;
      e.wr = 5; e.valid = 1; e.regwrite = 1;
      sb.push_back(e);
      tick();
      compare("zero_imm");

      // Load-use via rs, then flush+stall together
      @(negedge clk);
      clear_inputs();
      valid_d = 1; memtoreg_d = 1; regwrite_d = 1; rt_d = 9; rs_d = 2;
      rd1_d = 32'h100; rd2_d = 32'h200; signimm_d = 4; alusrc_d = 1;
      alucontrol_d = 3'b010;
      e = bubble(); e.srca = 32'h100; e.srcb = 4; e.wd = 32'h200; e.wr = 9;
      e.valid = 1; e.regwrite = 1; e.memtoreg = 1; e.lwstall = 1;
      sb.push_back(e);
      tick();
      rs_d = 9; rt_d = 1; memtoreg_d = 0;
      #1;
      compare("lwuse_rs");
      flush_e = 1; stall_e = 1;
      sb.push_back(bubble());
      tick();
      compare("flush_stall");

      // Load-use via rt
      @(negedge clk);
      clear_inputs();
      valid_d = 1; memtoreg_d = 1; regwrite_d = 1; rt_d = 12; rs_d = 3;
      rd1_d = 32'h300; signimm_d = 8; alusrc_d = 1; alucontrol_d = 3'b010;
      e = bubble(); e.srca = 32'h300; e.srcb = 8; e.wr = 12;
      e.valid = 1; e.regwrite = 1; e.memtoreg = 1; e.lwstall = 1;
      sb.push_back(e);
      tick();
      rs_d = 4; rt_d = 12; memtoreg_d = 0;
      #1;
      compare("lwuse_rt");

      // Load into $0 never stalls
      @(negedge clk);
      clear_inputs();
      valid_d = 1; memtoreg_d = 1; regwrite_d = 1; rt_d = 0; rs_d = 0;
      rd1_d = 32'h40; signimm_d = 8; alusrc_d = 1; alucontrol_d = 3'b010;
      e = bubble(); e.srca = 32'h40; e.srcb = 8; e.wr = 0;
      e.valid = 1; e.regwrite = 1; e.memtoreg = 1; e.lwstall = 0;
      sb.push_back(e);
      tick();
      compare("lw_zero");

      // Stall hold with changing decode data, then WB arrives mid-stall
      @(negedge clk);
      clear_inputs();
      valid_d = 1; rs_d = 7; rt_d = 10; rd_d = 11; regdst_d = 1;
      rd1_d = 32'h7000; rd2_d = 32'hA000; alucontrol_d = 3'b001; regwrite_d = 1;
      e = bubble(); e.srca = 32'h7000; e.srcb = 32'hA000; e.wd = 32'hA000;
      e.alucont = 3'b001; e.wr = 11; e.valid = 1; e.regwrite = 1;
      sb.push_back(e);
      tick();
      compare("hold_capture");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         stall_e = 1; rd1_d = 32'h9000 + i; rs_d = 5'(20 + i); alucontrol_d = 3'b111;
         sb.push_back(e);
         tick();
         compare("hold");
      end
      regwrite_w = 1; writereg_w = 7; result_w = 32'hBEEF;
      e.srca = 32'hBEEF; e.fa = 2'b01;
      sb.push_back(e);
      #1;
      compare("hold_wb_fwd");
      @(negedge clk);
      stall_e = 0;
      e.srca = 32'h9002; e.fa = 2'b00; e.alucont = 3'b111;
      sb.push_back(e);
      tick();
      compare("release");

      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL sb_drain: got %0d leftover entries expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
